// File: rtl/pipe_sink_fifo.sv
// Final buffer behind the last pipeline stage: valid/allowin on the input side,
// valid/ready on the output side, DEPTH-entry circular storage in between.
module pipe_sink_fifo #(
    parameter int WIDTH = 100,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         in_allowin,
    input  logic                         flush,
    output logic                         out_valid,
    output logic [WIDTH-1:0]             out_data,
    input  logic                         out_ready,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [PW-1:0]    wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0]    rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0]    count_reg, count_next;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0] wr_en;
    logic             push;
    logic             pop;

    // Allowin is derived from registered count only, so out_ready never
    // reaches upstream combinationally; a full FIFO refuses even while popping.
    assign in_allowin = (count_reg != CW'(DEPTH));
    assign out_valid  = (count_reg != '0);
    assign out_data   = mem[rd_ptr_reg];
    assign count      = count_reg;

    assign push = in_valid & in_allowin;
    assign pop  = out_valid & out_ready;

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            // DEPTH is a power of two, so the natural pointer overflow is the wrap.
            if (push) begin
                wr_ptr_next = wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_next = rd_ptr_reg + PW'(1);
            end
            if (push && !pop) begin
                count_next = count_reg + CW'(1);
            end else if (pop && !push) begin
                count_next = count_reg - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    // One-hot write enables; a flush cycle drops the offered entry.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_en
            assign wr_en[gi] = push && !flush && (wr_ptr_reg == PW'(gi));
        end
    endgenerate

    // Storage is cleared on reset so out_data reads zero while empty after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_en[i]) begin
                    mem[i] <= in_data;
                end
            end
        end
    end

endmodule
